// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Two-requester writeback arbiter in front of a single register-file write
// port. Each requester hands its result to a one-entry buffer. A round-robin
// grant drains one buffer per cycle into the registered write port.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   reqK_valid / reqK_ready   handshake for requester K (K = 0, 1)
//   reqK_idx/data/pc          destination index, value and producing PC
//   we, wa, wd, wpc           registered register-file write port
//   pending                   per-register "write buffered, not yet issued"
//   conflict_cnt              saturating count of cycles with both buffers full
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  localparam int NREG       = 2 ** RFIDX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rstn,

  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [RFIDX_WIDTH-1:0] req0_idx,
  input  logic [XLEN-1:0]        req0_data,
  input  logic [XLEN-1:0]        req0_pc,

  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [RFIDX_WIDTH-1:0] req1_idx,
  input  logic [XLEN-1:0]        req1_data,
  input  logic [XLEN-1:0]        req1_pc,

  output logic                   we,
  output logic [RFIDX_WIDTH-1:0] wa,
  output logic [XLEN-1:0]        wd,
  output logic [XLEN-1:0]        wpc,
  output logic [NREG-1:0]        pending,
  output logic [15:0]            conflict_cnt
);

  // One-entry buffers, one per requester.
  logic                   buf0_full, buf1_full;
  logic [RFIDX_WIDTH-1:0] buf0_idx,  buf1_idx;
  logic [XLEN-1:0]        buf0_data, buf1_data;
  logic [XLEN-1:0]        buf0_pc,   buf1_pc;

  // Requester granted most recently (0 or 1). Resetting to 1 lets requester 0
  // win the first contention.
  logic last_grant;

  logic grant0, grant1, grant_any;
  logic xfer0, xfer1;
  logic both_full;

  logic [RFIDX_WIDTH-1:0] sel_idx;
  logic [XLEN-1:0]        sel_data;
  logic [XLEN-1:0]        sel_pc;

  // ---------------------------------------------------------------------------
  // Grant: a lone full buffer always wins; under contention the buffer that
  // was not granted last time wins.
  // ---------------------------------------------------------------------------
  assign both_full = buf0_full && buf1_full;
  assign grant0    = buf0_full && (!buf1_full || last_grant);
  assign grant1    = buf1_full && (!buf0_full || !last_grant);
  assign grant_any = grant0 || grant1;

  // Ready frees up in the same cycle the buffer drains, so a granted buffer can
  // be refilled at the same edge. Deliberately independent of valid.
  assign req0_ready = !buf0_full || grant0;
  assign req1_ready = !buf1_full || grant1;

  assign xfer0 = req0_valid && req0_ready;
  assign xfer1 = req1_valid && req1_ready;

  // Write-port source mux; grant0 and grant1 are mutually exclusive.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sel_idx  = buf1_idx;
    sel_data = buf1_data;
    sel_pc   = buf1_pc;
    if (grant0) begin
      sel_idx  = buf0_idx;
      sel_data = buf0_data;
      sel_pc   = buf0_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Buffers. A transfer wins over the drain so grant-plus-refill keeps the
  // buffer full with the new contents.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!rstn) begin
      buf0_full <= 1'b0;
      buf0_idx  <= '0;
      buf0_data <= '0;
      buf0_pc   <= '0;
    end else if (xfer0) begin
      buf0_full <= 1'b1;
      buf0_idx  <= req0_idx;
      buf0_data <= req0_data;
      buf0_pc   <= req0_pc;
    end else if (grant0) begin
      buf0_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf1_full <= 1'b0;
      buf1_idx  <= '0;
      buf1_data <= '0;
      buf1_pc   <= '0;
    end else if (xfer1) begin
      buf1_full <= 1'b1;
      buf1_idx  <= req1_idx;
      buf1_data <= req1_data;
      buf1_pc   <= req1_pc;
    end else if (grant1) begin
      buf1_full <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin pointer and registered write port.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant <= 1'b1;
    end else if (grant_any) begin
      last_grant <= grant1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we  <= 1'b0;
      wa  <= '0;
      wd  <= '0;
      wpc <= '0;
    end else begin
      // x0 writes are consumed like any other but never raise we.
      we <= grant_any && (sel_idx != '0);
      if (grant_any) begin
        wa  <= sel_idx;
        wd  <= sel_data;
        wpc <= sel_pc;
      end
    end
  end

  // Saturating contention counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      conflict_cnt <= '0;
    end else if (both_full && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending scoreboard; register 0 is never pending.
  // ---------------------------------------------------------------------------
  always_comb begin
    pending = '0;
    for (int i = 1; i < NREG; i++) begin
      pending[i] = (buf0_full && (buf0_idx == RFIDX_WIDTH'(i))) ||
                   (buf1_full && (buf1_idx == RFIDX_WIDTH'(i)));
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Directed bench for wb_arbiter. Inputs change 1 time unit after a rising edge
// and outputs are checked at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int XLEN        = 32;
  localparam int RFIDX_WIDTH = 5;
  localparam int NREG        = 2 ** RFIDX_WIDTH;

  logic                   clk;
  logic                   rstn;
  logic                   req0_valid, req1_valid;
  logic                   req0_ready, req1_ready;
  logic [RFIDX_WIDTH-1:0] req0_idx,   req1_idx;
  logic [XLEN-1:0]        req0_data,  req1_data;
  logic [XLEN-1:0]        req0_pc,    req1_pc;
  logic                   we;
  logic [RFIDX_WIDTH-1:0] wa;
  logic [XLEN-1:0]        wd;
  logic [XLEN-1:0]        wpc;
  logic [NREG-1:0]        pending;
  logic [15:0]            conflict_cnt;

  int n_asserts;
  int n_fails;

  wb_arbiter #(
    .XLEN        (XLEN),
    .RFIDX_WIDTH (RFIDX_WIDTH)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_idx     (req0_idx),
    .req0_data    (req0_data),
    .req0_pc      (req0_pc),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_idx     (req1_idx),
    .req1_data    (req1_data),
    .req1_pc      (req1_pc),
    .we           (we),
    .wa           (wa),
    .wd           (wd),
    .wpc          (wpc),
    .pending      (pending),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_idx = '0; req0_data = '0; req0_pc = '0;
    req1_valid = 1'b0; req1_idx = '0; req1_data = '0; req1_pc = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    n_asserts = 0;
    n_fails   = 0;
    rstn      = 1'b0;
    idle_inputs();

    // ---------------- reset state ----------------
    apply_reset();
    check("rst_we",      64'(we), 64'd0);
    check("rst_wa",      64'(wa), 64'd0);
    check("rst_wd",      64'(wd), 64'd0);
    check("rst_wpc",     64'(wpc), 64'd0);
    check("rst_cnt",     64'(conflict_cnt), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_ready0",  64'(req0_ready), 64'd1);
    check("rst_ready1",  64'(req1_ready), 64'd1);

    // ---------------- single write ----------------
    req0_valid = 1'b1; req0_idx = 5'd5; req0_data = 32'h1234; req0_pc = 32'h100;
    tick();                                   // accepted
    req0_valid = 1'b0;
    check("single_pend",   64'(pending), 64'h20);
    check("single_we0",    64'(we), 64'd0);
    tick();                                   // issued
    check("single_we",     64'(we), 64'd1);
    check("single_wa",     64'(wa), 64'd5);
    check("single_wd",     64'(wd), 64'h1234);
    check("single_wpc",    64'(wpc), 64'h100);
    check("single_pend0",  64'(pending), 64'd0);
    tick();
    check("single_we_off", 64'(we), 64'd0);
    check("single_wa_hold", 64'(wa), 64'd5);
    check("single_wd_hold", 64'(wd), 64'h1234);

    // ---------------- contention ----------------
    apply_reset();
    req0_valid = 1'b1; req0_idx = 5'd3; req0_data = 32'hAAAA; req0_pc = 32'h200;
    req1_valid = 1'b1; req1_idx = 5'd7; req1_data = 32'hBBBB; req1_pc = 32'h300;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("cont_ready0",  64'(req0_ready), 64'd1);
    check("cont_ready1",  64'(req1_ready), 64'd0);
    check("cont_pend",    64'(pending), 64'h88);
    check("cont_cnt0",    64'(conflict_cnt), 64'd0);
    tick();
    check("cont_we_a",    64'(we), 64'd1);
    check("cont_wa_a",    64'(wa), 64'd3);
    check("cont_wpc_a",   64'(wpc), 64'h200);
    check("cont_cnt1",    64'(conflict_cnt), 64'd1);
    check("cont_ready1b", 64'(req1_ready), 64'd1);
    check("cont_pend_b",  64'(pending), 64'h80);
    tick();
    check("cont_we_b",    64'(we), 64'd1);
    check("cont_wa_b",    64'(wa), 64'd7);
    check("cont_wd_b",    64'(wd), 64'hBBBB);
    check("cont_cnt_end", 64'(conflict_cnt), 64'd1);
    tick();
    check("cont_we_off",  64'(we), 64'd0);

    // ---------------- back-to-back streaming ----------------
    apply_reset();
    for (int k = 1; k <= 8; k++) begin
      req0_valid = 1'b1;
      req0_idx   = RFIDX_WIDTH'(k);
      req0_data  = 32'(k * 16);
      req0_pc    = 32'h1000 + 32'(k * 4);
      check($sformatf("stream_ready_%0d", k), 64'(req0_ready), 64'd1);
      tick();
      if (k >= 2) begin
        check($sformatf("stream_we_%0d", k), 64'(we), 64'd1);
        check($sformatf("stream_wa_%0d", k), 64'(wa), 64'(k - 1));
      end
    end
    req0_valid = 1'b0;
    tick();
    check("stream_we_last", 64'(we), 64'd1);
    check("stream_wa_last", 64'(wa), 64'd8);
    check("stream_wd_last", 64'(wd), 64'd128);
    tick();
    check("stream_we_off",  64'(we), 64'd0);

    // ---------------- fairness ----------------
    apply_reset();
    req0_valid = 1'b1; req0_idx = 5'd10; req0_data = 32'hC0; req0_pc = 32'h400;
    req1_valid = 1'b1; req1_idx = 5'd11; req1_data = 32'hC1; req1_pc = 32'h500;
    tick();
    check("fair_we_e1",  64'(we), 64'd0);
    check("fair_cnt_e1", 64'(conflict_cnt), 64'd0);
    for (int k = 2; k <= 10; k++) begin
      tick();
      check($sformatf("fair_we_%0d", k),  64'(we), 64'd1);
      check($sformatf("fair_wa_%0d", k),  64'(wa), (k % 2 == 0) ? 64'd10 : 64'd11);
      check($sformatf("fair_cnt_%0d", k), 64'(conflict_cnt), 64'(k - 1));
      check($sformatf("fair_rdy0_%0d", k), 64'(req0_ready), (k % 2 == 1) ? 64'd1 : 64'd0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("fair_wa_11",  64'(wa), 64'd11);
    check("fair_cnt_11", 64'(conflict_cnt), 64'd10);
    tick();
    check("fair_wa_12",  64'(wa), 64'd10);
    check("fair_cnt_12", 64'(conflict_cnt), 64'd10);
    tick();
    check("fair_we_off", 64'(we), 64'd0);

    // ---------------- x0 write ----------------
    apply_reset();
    req1_valid = 1'b1; req1_idx = 5'd0; req1_data = 32'hFFFF; req1_pc = 32'h600;
    check("x0_ready", 64'(req1_ready), 64'd1);
    tick();
    req1_valid = 1'b0;
    check("x0_pend_a", 64'(pending), 64'd0);
    check("x0_we_a",   64'(we), 64'd0);
    tick();
    check("x0_we_b",   64'(we), 64'd0);
    check("x0_pend_b", 64'(pending), 64'd0);
    check("x0_wd",     64'(wd), 64'hFFFF);
    check("x0_ready_b", 64'(req1_ready), 64'd1);
    tick();
    check("x0_we_c",   64'(we), 64'd0);

    // ---------------- reset mid-operation ----------------
    apply_reset();
    req0_valid = 1'b1; req0_idx = 5'd4; req0_data = 32'hD4; req0_pc = 32'h700;
    req1_valid = 1'b1; req1_idx = 5'd9; req1_data = 32'hD9; req1_pc = 32'h800;
    tick();
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("mid_we_pre",   64'(we), 64'd1);
    check("mid_cnt_pre",  64'(conflict_cnt), 64'd1);
    check("mid_pend_pre", 64'(pending), 64'h210);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_we",      64'(we), 64'd0);
    check("mid_wa",      64'(wa), 64'd0);
    check("mid_wd",      64'(wd), 64'd0);
    check("mid_wpc",     64'(wpc), 64'd0);
    check("mid_cnt",     64'(conflict_cnt), 64'd0);
    check("mid_pend",    64'(pending), 64'd0);
    tick();
    rstn = 1'b1;
    tick();
    check("mid_we_rel1", 64'(we), 64'd0);
    check("mid_rdy0",    64'(req0_ready), 64'd1);
    check("mid_rdy1",    64'(req1_ready), 64'd1);
    tick();
    check("mid_we_rel2", 64'(we), 64'd0);
    check("mid_wa_rel",  64'(wa), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data width of writeback values and PCs.
REQ-002 Parameter RFIDX_WIDTH, default 5, register index width; register count is 2**RFIDX_WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 reqK_valid  input  1  (K=0,1) requester K offers a write.
REQ-006 reqK_ready  output  1  (K=0,1) requester K write accepted this cycle when valid is also high.
REQ-007 reqK_idx  input  RFIDX_WIDTH  (K=0,1) destination register index.
REQ-008 reqK_data  input  XLEN  (K=0,1) write value.
REQ-009 reqK_pc  input  XLEN  (K=0,1) PC of the producing instruction.
REQ-010 we  output  1  register-file write enable, registered.
REQ-011 wa  output  RFIDX_WIDTH  register-file write index, registered.
REQ-012 wd  output  XLEN  register-file write data, registered.
REQ-013 wpc  output  XLEN  PC of the write, registered.
REQ-014 pending  output  2**RFIDX_WIDTH  bit i high when a write to register i is buffered but not yet issued.
REQ-015 conflict_cnt  output  16  saturating count of contention cycles.

Function
REQ-016 Each requester SHALL own a one-entry buffer (full flag, idx, data, pc).
REQ-017 Handshake: transfer on reqK_valid && reqK_ready at a rising edge; the buffer captures idx/data/pc and sets full.
REQ-018 reqK_ready SHALL equal (!bufK_full || grantK); it SHALL NOT depend on reqK_valid.
REQ-019 Grant: if exactly one buffer is full, it is granted; if both are full, the buffer not granted most recently wins (round robin); if neither, no grant.
REQ-020 last_grant SHALL update to the granted requester on every grant; it holds when there is no grant.
REQ-021 A granted buffer SHALL clear at the same edge unless simultaneously refilled (grant plus transfer), in which case it stays full with the new contents.
REQ-022 On a grant, we/wa/wd/wpc SHALL load the granted buffer at the same edge; we = 1 unless the granted idx is 0.
REQ-023 Latency: accept at edge E, we high in the cycle after edge E+1 at the earliest; minimum 2 cycles valid-to-write, 1 write per cycle maximum.
REQ-024 With no grant, we SHALL load 0 and wa/wd/wpc SHALL hold their previous values.
REQ-025 Writes to index 0 SHALL be accepted and consumed normally but never assert we or a pending bit.
REQ-026 pending SHALL be combinational: bit i = (buf0_full && buf0_idx==i) || (buf1_full && buf1_idx==i), for i != 0; bit 0 is constant 0.
REQ-027 Both buffers holding the same idx SHALL issue in grant order; the later write is the final register value.
REQ-028 conflict_cnt SHALL increment on every cycle in which both buffers are full, and saturate at 0xFFFF.
REQ-029 A requester whose buffer is full and not granted SHALL see ready low and its buffer contents SHALL remain unchanged.

Reset
REQ-030 On rstn low, asynchronously: both full flags 0, last_grant = 1 (requester 0 wins first contention), we = 0, wa = 0, wd = 0, wpc = 0, conflict_cnt = 0.
REQ-031 Reset mid-operation SHALL discard buffered writes without issuing them; we SHALL be 0 in the first cycle after release.
REQ-032 After reset, reqK_ready SHALL be 1 for both requesters.

Verification
REQ-033 Single write: req0 idx=5 data=0x1234 pc=0x100 for one cycle -> two cycles later we=1 wa=5 wd=0x1234 wpc=0x100 for one cycle; pending[5] high for exactly one cycle.
REQ-034 Contention: both valid at the same edge, idx 3/7, after reset -> x3 written first, then x7 on the next cycle; conflict_cnt=1; req1_ready low for one cycle.
REQ-035 Back-to-back streaming: req0 valid for 8 cycles with idx 1..8 and no req1 -> ready stays high, we is high for 8 consecutive cycles, and wa takes the values 1..8 in order.
REQ-036 Fairness: both requesters valid continuously for 10 cycles -> grants alternate 0,1,0,1...; conflict_cnt increments each contended cycle.
REQ-037 x0 write: req1 idx=0 data=0xFFFF -> handshake completes, we stays 0, pending stays all-zero.
REQ-038 Reset mid-operation: assert rstn low while both buffers are full -> outputs become 0 immediately; no write is issued after release; both ready signals are 1.
